// File: rtl/branch_sequencer.sv
// Control-step sequencer for conditional-branch instructions: fetch T0-T2, then
// CON FF load, PC+C computation and CONFF-gated PC load in T3-T6.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC -> MAR, increment PC into Z
// T1    | memory read of instruction word, waits on mem_ready
// T2    | MDR -> IR
// T3    | opcode decode; branch loads CON FF from Ra
// T4    | PC -> Y
// T5    | Y + C -> Z
// T6    | Zlow -> PC when CONFF is set
// DONE  | one-cycle completion pulse
// ERR   | fetch timed out; sticky until next start
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE   = 5'b10010,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       mem_ready,
  input  logic [4:0] ir_op,
  input  logic       con_ff,
  output logic       pc_out,
  output logic       mar_in,
  output logic       inc_pc,
  output logic       z_in,
  output logic       zlow_out,
  output logic       pc_in,
  output logic       read,
  output logic       mdata_in,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       gra,
  output logic       r_out,
  output logic       con_in,
  output logic       y_in,
  output logic       c_out,
  output logic       alu_add,
  output logic       busy,
  output logic       done,
  output logic       taken,
  output logic       not_branch,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, ERR
  } seqState_t;

  typedef struct packed {
    logic pcOut;
    logic marIn;
    logic incPc;
    logic zIn;
    logic zlowOut;
    logic pcIn;
    logic read;
    logic mdataIn;
    logic mdrOut;
    logic irIn;
    logic gra;
    logic rOut;
    logic conIn;
    logic yIn;
    logic cOut;
    logic aluAdd;
    logic busy;
    logic done;
  } strobe_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  seqState_t        state;
  seqState_t        nextState;
  logic [CNT_W-1:0] waitCnt;
  strobe_t          strb;
  logic             firstT1;
  logic             timeoutHit;
  logic             isBranch;

  assign firstT1    = (waitCnt == '0);
  assign timeoutHit = (waitCnt == LAST_WAIT);
  assign isBranch   = (ir_op == BR_OPCODE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = T0;
      T0:   nextState = T1;
      T1: begin
        if (mem_ready)       nextState = T2;
        else if (timeoutHit) nextState = ERR;
      end
      T2:   nextState = T3;
      T3:   nextState = isBranch ? T4 : DONE;
      T4:   nextState = T5;
      T5:   nextState = T6;
      T6:   nextState = DONE;
      DONE: nextState = IDLE;
      ERR:  if (start) nextState = T0;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    strb      = '0;
    strb.busy = (state != IDLE);
    case (state)
      T0: begin
        strb.pcOut = 1'b1;
        strb.marIn = 1'b1;
        strb.incPc = 1'b1;
        strb.zIn   = 1'b1;
      end
      T1: begin
        strb.zlowOut = firstT1;
        strb.pcIn    = firstT1;
        strb.read    = 1'b1;
        strb.mdataIn = 1'b1;
      end
      T2: begin
        strb.mdrOut = 1'b1;
        strb.irIn   = 1'b1;
      end
      T3: begin
        strb.gra   = isBranch;
        strb.rOut  = isBranch;
        strb.conIn = isBranch;
      end
      T4: begin
        strb.pcOut = 1'b1;
        strb.yIn   = 1'b1;
      end
      T5: begin
        strb.cOut   = 1'b1;
        strb.aluAdd = 1'b1;
        strb.zIn    = 1'b1;
      end
      T6: begin
        strb.zlowOut = 1'b1;
        strb.pcIn    = con_ff;
      end
      DONE: strb.done = 1'b1;
      default: ;
    endcase
  end

  // Wait counter only runs in T1; it saturates on the timeout value and is
  // cleared everywhere else, so every fresh T1 starts at zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      waitCnt <= '0;
    end else if (state == T1 && !mem_ready) begin
      if (!timeoutHit) waitCnt <= waitCnt + CNT_W'(1);
    end else begin
      waitCnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      taken      <= 1'b0;
      not_branch <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (state == T3) begin
        if (!isBranch) begin
          not_branch <= 1'b1;
          taken      <= 1'b0;
        end else begin
          not_branch <= 1'b0;
        end
      end
      if (state == T6) taken <= con_ff;
      if (state == T1 && !mem_ready && timeoutHit) err <= 1'b1;
      else if (state == ERR && start)              err <= 1'b0;
    end
  end

  // Outputs are forced low while clr is held so nothing pulses during an abort.
  assign pc_out   = strb.pcOut   & ~clr;
  assign mar_in   = strb.marIn   & ~clr;
  assign inc_pc   = strb.incPc   & ~clr;
  assign z_in     = strb.zIn     & ~clr;
  assign zlow_out = strb.zlowOut & ~clr;
  assign pc_in    = strb.pcIn    & ~clr;
  assign read     = strb.read    & ~clr;
  assign mdata_in = strb.mdataIn & ~clr;
  assign mdr_out  = strb.mdrOut  & ~clr;
  assign ir_in    = strb.irIn    & ~clr;
  assign gra      = strb.gra     & ~clr;
  assign r_out    = strb.rOut    & ~clr;
  assign con_in   = strb.conIn   & ~clr;
  assign y_in     = strb.yIn     & ~clr;
  assign c_out    = strb.cOut    & ~clr;
  assign alu_add  = strb.aluAdd  & ~clr;
  assign busy     = strb.busy    & ~clr;
  assign done     = strb.done    & ~clr;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: per-cycle strobe tables for each
// instruction flavour, fetch wait/timeout, back-to-back starts and bus exclusivity.
module tb_branch_sequencer;

  localparam logic [4:0] BR_OP = 5'b10010;
  localparam logic [4:0] NB_OP = 5'b00011;

  localparam logic [15:0] S_PCOUT  = 16'h8000;
  localparam logic [15:0] S_MARIN  = 16'h4000;
  localparam logic [15:0] S_INCPC  = 16'h2000;
  localparam logic [15:0] S_ZIN    = 16'h1000;
  localparam logic [15:0] S_ZLOW   = 16'h0800;
  localparam logic [15:0] S_PCIN   = 16'h0400;
  localparam logic [15:0] S_READ   = 16'h0200;
  localparam logic [15:0] S_MDATA  = 16'h0100;
  localparam logic [15:0] S_MDROUT = 16'h0080;
  localparam logic [15:0] S_IRIN   = 16'h0040;
  localparam logic [15:0] S_GRA    = 16'h0020;
  localparam logic [15:0] S_ROUT   = 16'h0010;
  localparam logic [15:0] S_CONIN  = 16'h0008;
  localparam logic [15:0] S_YIN    = 16'h0004;
  localparam logic [15:0] S_COUT   = 16'h0002;
  localparam logic [15:0] S_ALUADD = 16'h0001;

  localparam logic [15:0] E_T0  = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [15:0] E_T1F = S_ZLOW | S_PCIN | S_READ | S_MDATA;
  localparam logic [15:0] E_T1W = S_READ | S_MDATA;
  localparam logic [15:0] E_T2  = S_MDROUT | S_IRIN;
  localparam logic [15:0] E_T3B = S_GRA | S_ROUT | S_CONIN;
  localparam logic [15:0] E_T4  = S_PCOUT | S_YIN;
  localparam logic [15:0] E_T5  = S_COUT | S_ALUADD | S_ZIN;
  localparam logic [15:0] E_T6  = S_ZLOW;
  localparam logic [15:0] BUS   = S_PCOUT | S_ZLOW | S_MDROUT | S_ROUT | S_COUT;

  logic       clk, clr, start, mem_ready, con_ff;
  logic [4:0] ir_op;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdata_in;
  logic mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add;
  logic busy, done, taken, not_branch, err;
  logic [15:0] strobes;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] trc [0:63];

  branch_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir_op(ir_op),
    .con_ff(con_ff), .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .read(read), .mdata_in(mdata_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .r_out(r_out), .con_in(con_in),
    .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .busy(busy), .done(done),
    .taken(taken), .not_branch(not_branch), .err(err)
  );

  assign strobes = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdata_in,
                    mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge while IDLE; returns at the negedge of the done cycle.
  task automatic runInstr(input int memWaits, input logic [4:0] op, input logic cf,
                          input bit holdStart, output int doneCyc);
    ir_op = op; con_ff = cf; start = 1'b1; mem_ready = 1'b0;
    doneCyc = 0;
    for (int c = 1; c <= 60 && doneCyc == 0; c++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      trc[c] = strobes;
      if (done) doneCyc = c;
      mem_ready = (c >= 2 + memWaits);
    end
    if (!holdStart) start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_op = '0; con_ff = 1'b0;
    @(negedge clk);
    testsRun++;
    if (strobes !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        taken !== 1'b0 || not_branch !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_state: strobes=%h busy=%b done=%b err=%b taken=%b nb=%b, expected all 0",
               strobes, busy, done, err, taken, not_branch);
    end
    clr = 1'b0;
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b1; ir_op = BR_OP; con_ff = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    testsRun++;
    if (strobes !== E_T4) begin
      testsFailed++;
      $display("FAIL reset_reach_t4: got %h expected %h", strobes, E_T4);
    end
    #2 clr = 1'b1;
    #1;
    testsRun++;
    if (strobes !== 16'h0 || busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_abort: strobes=%h busy=%b expected 0/0", strobes, busy);
    end
    start = 1'b1;
    @(negedge clk);
    testsRun++;
    if (strobes !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_hold: strobes=%h busy=%b done=%b expected 0", strobes, busy, done);
    end
    clr = 1'b0; start = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || err !== 1'b0 || strobes !== 16'h0) begin
      testsFailed++;
      $display("FAIL reset_idle: busy=%b err=%b strobes=%h expected 0", busy, err, strobes);
    end
  endtask

  task automatic test_taken();
    int dc;
    logic [15:0] exp [1:8];
    exp = '{E_T0, E_T1F, E_T2, E_T3B, E_T4, E_T5, E_T6 | S_PCIN, 16'h0000};
    runInstr(0, BR_OP, 1'b1, 1'b0, dc);
    testsRun++;
    if (dc !== 8) begin
      testsFailed++;
      $display("FAIL taken_latency: got %0d expected 8", dc);
    end
    for (int c = 1; c <= 8; c++) begin
      testsRun++;
      if (trc[c] !== exp[c]) begin
        testsFailed++;
        $display("FAIL taken_strobes cyc %0d: got %h expected %h", c, trc[c], exp[c]);
      end
    end
    testsRun++;
    if (taken !== 1'b1 || not_branch !== 1'b0) begin
      testsFailed++;
      $display("FAIL taken_flags: taken=%b nb=%b expected 1/0", taken, not_branch);
    end
    @(negedge clk);
    testsRun++;
    if (taken !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL taken_hold: taken=%b done=%b busy=%b expected 1/0/0", taken, done, busy);
    end
  endtask

  task automatic test_non_branch();
    int dc;
    logic [15:0] exp [1:5];
    logic [15:0] seen;
    exp = '{E_T0, E_T1F, E_T2, 16'h0000, 16'h0000};
    runInstr(0, NB_OP, 1'b1, 1'b0, dc);
    testsRun++;
    if (dc !== 5) begin
      testsFailed++;
      $display("FAIL nonbr_latency: got %0d expected 5", dc);
    end
    seen = '0;
    for (int c = 1; c <= 5; c++) begin
      seen = seen | trc[c];
      testsRun++;
      if (trc[c] !== exp[c]) begin
        testsFailed++;
        $display("FAIL nonbr_strobes cyc %0d: got %h expected %h", c, trc[c], exp[c]);
      end
    end
    testsRun++;
    if ((seen & (S_CONIN | S_YIN | S_COUT)) !== 16'h0) begin
      testsFailed++;
      $display("FAIL nonbr_no_exec: got %h expected 0000", seen & (S_CONIN | S_YIN | S_COUT));
    end
    testsRun++;
    if (not_branch !== 1'b1 || taken !== 1'b0) begin
      testsFailed++;
      $display("FAIL nonbr_flags: nb=%b taken=%b expected 1/0", not_branch, taken);
    end
    @(negedge clk);
  endtask

  task automatic test_not_taken();
    int dc;
    runInstr(0, BR_OP, 1'b0, 1'b0, dc);
    testsRun++;
    if (dc !== 8) begin
      testsFailed++;
      $display("FAIL nottaken_latency: got %0d expected 8", dc);
    end
    testsRun++;
    if (trc[2] !== E_T1F || trc[4] !== E_T3B || trc[7] !== E_T6) begin
      testsFailed++;
      $display("FAIL nottaken_strobes: t1=%h t3=%h t6=%h expected %h %h %h",
               trc[2], trc[4], trc[7], E_T1F, E_T3B, E_T6);
    end
    testsRun++;
    if (taken !== 1'b0 || not_branch !== 1'b0) begin
      testsFailed++;
      $display("FAIL nottaken_flags: taken=%b nb=%b expected 0/0", taken, not_branch);
    end
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    int dc;
    runInstr(3, BR_OP, 1'b1, 1'b0, dc);
    testsRun++;
    if (dc !== 11) begin
      testsFailed++;
      $display("FAIL wait3_latency: got %0d expected 11", dc);
    end
    testsRun++;
    if (trc[2] !== E_T1F || trc[3] !== E_T1W || trc[5] !== E_T1W || trc[6] !== E_T2) begin
      testsFailed++;
      $display("FAIL wait3_strobes: %h %h %h %h expected %h %h %h %h",
               trc[2], trc[3], trc[5], trc[6], E_T1F, E_T1W, E_T1W, E_T2);
    end
    @(negedge clk);
    runInstr(15, BR_OP, 1'b0, 1'b0, dc);
    testsRun++;
    if (dc !== 23 || err !== 1'b0) begin
      testsFailed++;
      $display("FAIL wait15_edge: latency=%0d err=%b expected 23/0", dc, err);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int dc;
    start = 1'b1; mem_ready = 1'b0; ir_op = BR_OP; con_ff = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    testsRun++;
    if (strobes !== E_T1W || err !== 1'b0) begin
      testsFailed++;
      $display("FAIL timeout_last_wait: strobes=%h err=%b expected %h/0", strobes, err, E_T1W);
    end
    @(negedge clk);
    testsRun++;
    if (err !== 1'b1 || strobes !== 16'h0 || busy !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("FAIL timeout_err: err=%b strobes=%h busy=%b done=%b expected 1/0000/1/0",
               err, strobes, busy, done);
    end
    @(negedge clk);
    testsRun++;
    if (err !== 1'b1 || strobes !== 16'h0) begin
      testsFailed++;
      $display("FAIL timeout_sticky: err=%b strobes=%h expected 1/0000", err, strobes);
    end
    start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    testsRun++;
    if (err !== 1'b0 || strobes !== E_T0) begin
      testsFailed++;
      $display("FAIL timeout_restart: err=%b strobes=%h expected 0/%h", err, strobes, E_T0);
    end
    dc = 0;
    for (int c = 2; c <= 30 && dc == 0; c++) begin
      @(negedge clk);
      trc[c] = strobes;
      if (done) dc = c;
    end
    testsRun++;
    if (dc !== 8 || trc[2] !== E_T1F) begin
      testsFailed++;
      $display("FAIL timeout_recover: latency=%0d t1=%h expected 8/%h", dc, trc[2], E_T1F);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc;
    runInstr(0, BR_OP, 1'b1, 1'b0, dc);
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL b2b_idle: busy=%b expected 0", busy);
    end
    runInstr(0, NB_OP, 1'b0, 1'b0, dc);
    testsRun++;
    if (dc !== 5 || trc[1] !== E_T0) begin
      testsFailed++;
      $display("FAIL b2b_second: latency=%0d t0=%h expected 5/%h", dc, trc[1], E_T0);
    end
    @(negedge clk);
    runInstr(0, NB_OP, 1'b0, 1'b1, dc);
    testsRun++;
    if (dc !== 5) begin
      testsFailed++;
      $display("FAIL b2b_held_start: latency=%0d expected 5", dc);
    end
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL b2b_held_idle: busy=%b expected 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    testsRun++;
    if (strobes !== E_T0 || busy !== 1'b1) begin
      testsFailed++;
      $display("FAIL b2b_restart: strobes=%h busy=%b expected %h/1", strobes, busy, E_T0);
    end
    dc = 0;
    for (int c = 2; c <= 30 && dc == 0; c++) begin
      @(negedge clk);
      if (done) dc = c;
    end
    testsRun++;
    if (dc !== 5) begin
      testsFailed++;
      $display("FAIL b2b_third: latency=%0d expected 5", dc);
    end
    @(negedge clk);
  endtask

  task automatic test_bus_random();
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      ir_op     = ($urandom_range(0, 1) == 0) ? BR_OP : 5'($urandom_range(0, 31));
      con_ff    = 1'($urandom_range(0, 1));
      @(negedge clk);
      testsRun++;
      if ($countones(strobes & BUS) > 1) begin
        testsFailed++;
        $display("FAIL bus_exclusive cyc %0d: drivers=%h expected at most one", i, strobes & BUS);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_taken();
    test_non_branch();
    test_not_taken();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    test_bus_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
